// File: rtl/control_unit_if.sv
// Strobe and instruction bundle between the hardwired sequencer
// and the 32-bit bus datapath.
interface control_unit_if #(
  parameter int REGS = 16,
  parameter int OPW  = 13
);
  logic [31:0]     IR;
  logic            mem_ready;

  logic            PCout;
  logic            PCin;
  logic            IncPC;
  logic            MARin;

  logic            Read;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;

  logic            Yin;
  logic            Zin;
  logic            Zlowout;
  logic            Zhighout;
  logic            HIin;
  logic            LOin;

  logic [REGS-1:0] Rout;
  logic [REGS-1:0] Rin;
  logic [OPW-1:0]  alu_op;
  logic            Run;

  modport master (
    input  IR,
    input  mem_ready,
    output PCout,
    output PCin,
    output IncPC,
    output MARin,
    output Read,
    output MDRin,
    output MDRout,
    output IRin,
    output Yin,
    output Zin,
    output Zlowout,
    output Zhighout,
    output HIin,
    output LOin,
    output Rout,
    output Rin,
    output alu_op,
    output Run
  );

  modport slave (
    output IR,
    output mem_ready,
    input  PCout,
    input  PCin,
    input  IncPC,
    input  MARin,
    input  Read,
    input  MDRin,
    input  MDRout,
    input  IRin,
    input  Yin,
    input  Zin,
    input  Zlowout,
    input  Zhighout,
    input  HIin,
    input  LOin,
    input  Rout,
    input  Rin,
    input  alu_op,
    input  Run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired T-state sequencer: fetch via MAR/MDR, then Moore-decoded
// execute strobes for ALU, MUL/DIV, unary and HALT instructions.
module control_unit #(
  parameter int REGS = 16,
  parameter int OPW  = 13
) (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] state;
  logic [3:0] state_nxt;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;

  logic is_bin;
  logic is_md;
  logic is_un;
  logic is_halt;

  logic [OPW-1:0] alu_sel;

  logic pc_out;
  logic pc_in;
  logic inc_pc;
  logic mar_in;
  logic rd;
  logic mdr_in;
  logic mdr_out;
  logic ir_in;
  logic y_in;
  logic z_in;
  logic zlow_out;
  logic zhigh_out;
  logic hi_in;
  logic lo_in;
  logic run;

  logic [REGS-1:0] rout;
  logic [REGS-1:0] rin;

  logic unused_ir;

  assign opcode    = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];

  function automatic logic [REGS-1:0] onehot(
    input logic [3:0] idx
  );
    onehot = {{(REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_comb begin
    is_bin  = 1'b0;
    is_md   = 1'b0;
    is_un   = 1'b0;
    is_halt = 1'b0;
    alu_sel = '0;
    case (opcode)
      OP_AND:  begin is_bin = 1'b1; alu_sel[0]  = 1'b1; end
      OP_OR:   begin is_bin = 1'b1; alu_sel[1]  = 1'b1; end
      OP_ADD:  begin is_bin = 1'b1; alu_sel[2]  = 1'b1; end
      OP_SUB:  begin is_bin = 1'b1; alu_sel[3]  = 1'b1; end
      OP_MUL:  begin is_md  = 1'b1; alu_sel[4]  = 1'b1; end
      OP_DIV:  begin is_md  = 1'b1; alu_sel[5]  = 1'b1; end
      OP_SHR:  begin is_bin = 1'b1; alu_sel[6]  = 1'b1; end
      OP_SHRA: begin is_bin = 1'b1; alu_sel[7]  = 1'b1; end
      OP_SHL:  begin is_bin = 1'b1; alu_sel[8]  = 1'b1; end
      OP_ROR:  begin is_bin = 1'b1; alu_sel[9]  = 1'b1; end
      OP_ROL:  begin is_bin = 1'b1; alu_sel[10] = 1'b1; end
      OP_NEG:  begin is_un  = 1'b1; alu_sel[11] = 1'b1; end
      OP_NOT:  begin is_un  = 1'b1; alu_sel[12] = 1'b1; end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_nxt;
  end

  // Undefined opcodes fall out of T2 straight back into fetch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST: state_nxt = S_T0;
      S_T0:  state_nxt = S_T1;
      S_T1:  state_nxt = bus.mem_ready ? S_T2 : S_T1;
      S_T2: begin
        unique case (1'b1)
          is_halt:                state_nxt = S_HALT;
          is_bin | is_md | is_un: state_nxt = S_T3;
          default:                state_nxt = S_T0;
        endcase
      end
      S_T3:   state_nxt = (is_bin | is_md | is_un) ? S_T4 : S_T0;
      S_T4:   state_nxt = (is_bin | is_md) ? S_T5 : S_T0;
      S_T5:   state_nxt = is_md ? S_T6 : S_T0;
      S_T6:   state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    pc_out    = 1'b0;
    pc_in     = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    rd        = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    rout      = '0;
    rin       = '0;
    bus.alu_op = '0;
    case (state)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        pc_in  = 1'b1;
      end
      S_T1: begin
        rd     = 1'b1;
        mdr_in = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_bin: begin
            rout = onehot(rb);
            y_in = 1'b1;
          end
          is_md: begin
            rout = onehot(ra);
            y_in = 1'b1;
          end
          is_un: begin
            rout       = onehot(rb);
            bus.alu_op = alu_sel;
            z_in       = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          is_bin: begin
            rout       = onehot(rc);
            bus.alu_op = alu_sel;
            z_in       = 1'b1;
          end
          is_md: begin
            rout       = onehot(rb);
            bus.alu_op = alu_sel;
            z_in       = 1'b1;
          end
          is_un: begin
            zlow_out = 1'b1;
            rin      = onehot(ra);
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          is_bin: begin
            zlow_out = 1'b1;
            rin      = onehot(ra);
          end
          is_md: begin
            zlow_out = 1'b1;
            lo_in    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (is_md) begin
          zhigh_out = 1'b1;
          hi_in     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign run = (state != S_RST) && (state != S_HALT);

  assign bus.PCout    = pc_out;
  assign bus.PCin     = pc_in;
  assign bus.IncPC    = inc_pc;
  assign bus.MARin    = mar_in;
  assign bus.Read     = rd;
  assign bus.MDRin    = mdr_in;
  assign bus.MDRout   = mdr_out;
  assign bus.IRin     = ir_in;
  assign bus.Yin      = y_in;
  assign bus.Zin      = z_in;
  assign bus.Zlowout  = zlow_out;
  assign bus.Zhighout = zhigh_out;
  assign bus.HIin     = hi_in;
  assign bus.LOin     = lo_in;
  assign bus.Rout     = rout;
  assign bus.Rin      = rin;
  assign bus.Run      = run;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch, stall, each opcode class,
// halt, undefined opcode and asynchronous reset.
module tb_control_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  control_unit_if #(.REGS(16), .OPW(13)) bus ();

  control_unit #(.REGS(16), .OPW(13)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] PCOUT  = 15'h4000;
  localparam logic [14:0] PCIN   = 15'h2000;
  localparam logic [14:0] INCPC  = 15'h1000;
  localparam logic [14:0] MARIN  = 15'h0800;
  localparam logic [14:0] READ   = 15'h0400;
  localparam logic [14:0] MDRIN  = 15'h0200;
  localparam logic [14:0] MDROUT = 15'h0100;
  localparam logic [14:0] IRIN   = 15'h0080;
  localparam logic [14:0] YIN    = 15'h0040;
  localparam logic [14:0] ZIN    = 15'h0020;
  localparam logic [14:0] ZLOW   = 15'h0010;
  localparam logic [14:0] ZHIGH  = 15'h0008;
  localparam logic [14:0] HIIN   = 15'h0004;
  localparam logic [14:0] LOIN   = 15'h0002;
  localparam logic [14:0] RUN    = 15'h0001;

  localparam logic [14:0] F0 = PCOUT | PCIN | INCPC | MARIN | RUN;
  localparam logic [14:0] F1 = READ | MDRIN | RUN;
  localparam logic [14:0] F2 = MDROUT | IRIN | RUN;

  function automatic logic [59:0] obs();
    return {bus.PCout, bus.PCin, bus.IncPC, bus.MARin,
            bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
            bus.HIin, bus.LOin, bus.Run,
            bus.Rout, bus.Rin, bus.alu_op};
  endfunction

  function automatic logic [59:0] ex(
    input logic [14:0] s,
    input logic [15:0] ro,
    input logic [15:0] ri,
    input logic [12:0] a
  );
    return {s, ro, ri, a};
  endfunction

  function automatic logic [31:0] mk(
    input logic [4:0] op,
    input logic [3:0] ra,
    input logic [3:0] rb,
    input logic [3:0] rc
  );
    return {op, ra, rb, rc, 15'h0};
  endfunction

  task automatic chk(input string tag, input logic [59:0] e);
    logic [59:0] o;
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string p);
    cyc(); chk({p, "_t1"}, ex(F1, 0, 0, 0));
    cyc(); chk({p, "_t2"}, ex(F2, 0, 0, 0));
  endtask

  localparam logic [59:0] ZERO = 60'h0;

  initial begin
    reset         = 1'b1;
    bus.IR        = 32'h0;
    bus.mem_ready = 1'b1;
    cyc(); cyc();
    chk("rst_hold", ZERO);
    reset = 1'b0;
    chk("rst_idle", ZERO);
    cyc(); chk("first_t0", ex(F0, 0, 0, 0));

    // ADD R1,R2,R3 interrupted by reset in T4
    bus.IR = mk(5'b00011, 4'd1, 4'd2, 4'd3);
    fetch("add");
    cyc(); chk("add_t3", ex(YIN | RUN, 16'h0004, 0, 0));
    cyc(); chk("add_t4", ex(ZIN | RUN, 16'h0008, 0, 13'h0004));
    #2 reset = 1'b1;
    #1 chk("rst_async", ZERO);
    cyc(); chk("rst_held", ZERO);
    reset = 1'b0;
    cyc(); chk("rst_t0", ex(F0, 0, 0, 0));

    // AND R4,R3,R7
    bus.IR = 32'h2A1B8000;
    fetch("and");
    cyc(); chk("and_t3", ex(YIN | RUN, 16'h0008, 0, 0));
    cyc(); chk("and_t4", ex(ZIN | RUN, 16'h0080, 0, 13'h0001));
    cyc(); chk("and_t5", ex(ZLOW | RUN, 0, 16'h0010, 0));
    cyc(); chk("and_t0", ex(F0, 0, 0, 0));

    // three-cycle memory stall on a NOP fetch
    bus.IR        = mk(5'b00000, 4'd0, 4'd0, 4'd0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("stall_t1", ex(F1, 0, 0, 0));
    end
    bus.mem_ready = 1'b1;
    cyc(); chk("stall_t2", ex(F2, 0, 0, 0));
    cyc(); chk("stall_t0", ex(F0, 0, 0, 0));

    // MUL R2,R5
    bus.IR = 32'h79280000;
    fetch("mul");
    cyc(); chk("mul_t3", ex(YIN | RUN, 16'h0004, 0, 0));
    cyc(); chk("mul_t4", ex(ZIN | RUN, 16'h0020, 0, 13'h0010));
    cyc(); chk("mul_t5", ex(ZLOW | LOIN | RUN, 0, 0, 0));
    cyc(); chk("mul_t6", ex(ZHIGH | HIIN | RUN, 0, 0, 0));
    cyc(); chk("mul_t0", ex(F0, 0, 0, 0));

    // DIV R9,R10
    bus.IR = mk(5'b10000, 4'd9, 4'd10, 4'd0);
    fetch("div");
    cyc(); chk("div_t3", ex(YIN | RUN, 16'h0200, 0, 0));
    cyc(); chk("div_t4", ex(ZIN | RUN, 16'h0400, 0, 13'h0020));
    cyc(); cyc();
    cyc(); chk("div_t0", ex(F0, 0, 0, 0));

    // NOT R1,R6
    bus.IR = 32'h90B00000;
    fetch("not");
    cyc(); chk("not_t3", ex(ZIN | RUN, 16'h0040, 0, 13'h1000));
    cyc(); chk("not_t4", ex(ZLOW | RUN, 0, 16'h0002, 0));
    cyc(); chk("not_t0", ex(F0, 0, 0, 0));

    // SUB R5,R5,R5
    bus.IR = mk(5'b00100, 4'd5, 4'd5, 4'd5);
    fetch("sub");
    cyc(); chk("sub_t3", ex(YIN | RUN, 16'h0020, 0, 0));
    cyc(); chk("sub_t4", ex(ZIN | RUN, 16'h0020, 0, 13'h0008));
    cyc(); chk("sub_t5", ex(ZLOW | RUN, 0, 16'h0020, 0));
    cyc(); chk("sub_t0", ex(F0, 0, 0, 0));

    // undefined opcode
    bus.IR = 32'hF8000000;
    fetch("undef");
    cyc(); chk("undef_t0", ex(F0, 0, 0, 0));

    // reset during a memory stall
    bus.mem_ready = 1'b0;
    cyc(); chk("rs_t1", ex(F1, 0, 0, 0));
    cyc();
    reset = 1'b1;
    #1 chk("rs_async", ZERO);
    cyc();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    cyc(); chk("rs_t0", ex(F0, 0, 0, 0));

    // HALT, then reset out of it
    bus.IR = 32'hD8000000;
    fetch("halt");
    for (int i = 0; i < 10; i++) begin
      cyc(); chk("halt_idle", ZERO);
    end
    reset = 1'b1;
    #1 chk("halt_rst", ZERO);
    cyc();
    reset = 1'b0;
    cyc(); chk("halt_t0", ex(F0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
